// File: rtl/icache_pkg.sv
// Shared I-cache package: tag/valid entry layout, array FSM states
// and the replacement LFSR constants.
package icache_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    IDLE    = 2'd1,
    SWEEP   = 2'd2,
    INV_ONE = 2'd3
  } state_t;

  // x^8+x^6+x^5+x^4+1, right-shifting Galois form
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Valid sits directly above the tag in each stored entry
  function automatic int validBit(input int tagW);
    return tagW;
  endfunction

  function automatic logic [7:0] lfsrNext(
    input logic [7:0] cur
  );
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM, one write port and one read-first
// registered read port. Contents are not reset.
module bram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 21
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrAddr] <= wrData;
    if (rdEn) rdData <= mem[rdAddr];
  end

endmodule

// File: rtl/icache_victim_sel.sv
// Victim way pick: lowest invalid way, else LFSR-chosen way.
// Ports: adv steps the LFSR, en gates the one-hot victim output.
module icache_victim_sel
  import icache_pkg::*;
#(
  parameter int WAY = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           adv,
  input  logic           en,
  input  logic [WAY-1:0] wayValid,
  output logic [WAY-1:0] victim
);

  localparam int WAY_W = $clog2(WAY);

  logic [7:0]     lfsr;
  logic [WAY-1:0] pick;
  logic           found;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= LFSR_SEED;
    end else if (adv) begin
      lfsr <= lfsrNext(lfsr);
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < WAY; i++) begin
      if (!found && !wayValid[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    if (!found) begin
      pick = WAY'(1) << lfsr[WAY_W-1:0];
    end
    victim = en ? pick : '0;
  end

endmodule

// File: rtl/icache_tagv_nway.sv
// N-way I-cache tag/valid array with init/invalidate sweeps.
// Ports: lookup (rd_*), refill (wr_*), cacop (inv_*), hit/victim out.
module icache_tagv_nway
  import icache_pkg::*;
#(
  parameter int WAY     = 4,
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 20
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rd_en,
  input  logic [INDEX_W-1:0]     rd_index,
  input  logic [TAG_W-1:0]       rd_tag,
  input  logic                   wr_en,
  input  logic [WAY-1:0]         wr_way,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic                   wr_valid,
  input  logic                   inv_req,
  input  logic                   inv_all,
  input  logic [INDEX_W-1:0]     inv_index,
  output logic                   ready,
  output logic                   rd_out_valid,
  output logic [WAY-1:0]         hit,
  output logic                   hit_any,
  output logic [$clog2(WAY)-1:0] hit_way,
  output logic [WAY-1:0]         victim
);

  localparam int VALID_BIT = validBit(TAG_W);
  localparam int ENT_W     = TAG_W + 1;
  localparam int WAY_W     = $clog2(WAY);

  state_t state, stateNxt;
  logic [INDEX_W-1:0] cnt, cntNxt, invIdx;

  logic [WAY-1:0]     arrWe;
  logic [INDEX_W-1:0] arrIdx;
  logic [ENT_W-1:0]   arrData;
  logic [ENT_W-1:0]   dout [WAY];

  logic               rdLive;
  logic [TAG_W-1:0]   rdTagQ;
  logic [WAY-1:0]     fwdWe;
  logic [ENT_W-1:0]   fwdData;
  logic [ENT_W-1:0]   ent [WAY];
  logic [WAY-1:0]     wayValid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= INIT;
      cnt    <= '0;
      invIdx <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      if (state == IDLE && inv_req && !inv_all) begin
        invIdx <= inv_index;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      INIT, SWEEP: begin
        cntNxt = cnt + INDEX_W'(1);
        if (cnt == '1) stateNxt = IDLE;
      end
      IDLE: begin
        if (inv_req) begin
          stateNxt = inv_all ? SWEEP : INV_ONE;
          cntNxt   = '0;
        end
      end
      INV_ONE: stateNxt = IDLE;
      default: stateNxt = INIT;
    endcase
  end

  assign ready = (state == IDLE);

  // One shared write port into all ways; inv_req wins over wr_en
  always_comb begin
    arrWe   = '0;
    arrIdx  = wr_index;
    arrData = {wr_valid, wr_tag};
    unique case (state)
      INIT, SWEEP: begin
        arrWe   = '1;
        arrIdx  = cnt;
        arrData = '0;
      end
      INV_ONE: begin
        arrWe   = '1;
        arrIdx  = invIdx;
        arrData = '0;
      end
      IDLE: begin
        if (wr_en && !inv_req) arrWe = wr_way;
      end
      default: arrWe = '0;
    endcase
  end

  for (genvar g = 0; g < WAY; g++) begin : gWay
    bram #(
      .ADDR_W(INDEX_W),
      .DATA_W(ENT_W)
    ) uBram (
      .clk   (clk),
      .wrEn  (arrWe[g]),
      .wrAddr(arrIdx),
      .wrData(arrData),
      .rdEn  (rd_en),
      .rdAddr(rd_index),
      .rdData(dout[g])
    );
  end

  // The bram is read-first, so a same-set write is forwarded here
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_out_valid <= 1'b0;
      rdLive       <= 1'b0;
      rdTagQ       <= '0;
      fwdWe        <= '0;
      fwdData      <= '0;
    end else begin
      rd_out_valid <= rd_en;
      if (rd_en) begin
        rdLive  <= ready;
        rdTagQ  <= rd_tag;
        fwdWe   <= (arrIdx == rd_index) ? arrWe : '0;
        fwdData <= arrData;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WAY; i++) begin
      ent[i]      = fwdWe[i] ? fwdData : dout[i];
      wayValid[i] = ent[i][VALID_BIT];
      hit[i]      = rd_out_valid && rdLive &&
                    ent[i][VALID_BIT] &&
                    (ent[i][TAG_W-1:0] == rdTagQ);
    end
  end

  assign hit_any = |hit;

  always_comb begin
    hit_way = '0;
    for (int i = WAY - 1; i >= 0; i--) begin
      if (hit[i]) hit_way = WAY_W'(i);
    end
  end

  icache_victim_sel #(
    .WAY(WAY)
  ) uVictim (
    .clk     (clk),
    .rstn    (rstn),
    .adv     (rd_out_valid),
    .en      (rd_out_valid && rdLive),
    .wayValid(wayValid),
    .victim  (victim)
  );

endmodule

// File: tb/tb_icache_tagv_nway.sv
// Randomized bench for icache_tagv_nway against a behavioural
// array model (write-then-read view, LFSR sequence from seed).
module tb_icache_tagv_nway;

  localparam int WAY     = 4;
  localparam int INDEX_W = 6;
  localparam int TAG_W   = 20;
  localparam int SETS    = 1 << INDEX_W;

  logic               clk = 1'b0;
  logic               rstn;
  logic               rd_en;
  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   rd_tag;
  logic               wr_en;
  logic [WAY-1:0]     wr_way;
  logic [INDEX_W-1:0] wr_index;
  logic [TAG_W-1:0]   wr_tag;
  logic               wr_valid;
  logic               inv_req;
  logic               inv_all;
  logic [INDEX_W-1:0] inv_index;
  logic               ready;
  logic               rd_out_valid;
  logic [WAY-1:0]     hit;
  logic               hit_any;
  logic [1:0]         hit_way;
  logic [WAY-1:0]     victim;

  int nChk = 0;
  int nErr = 0;

  bit             mV [WAY][SETS];
  bit [TAG_W-1:0] mT [WAY][SETS];
  bit [7:0]       lfsrM;
  int             busy;
  bit             pendInv;
  bit             pendAll;
  int             pendIdx;

  always #5 clk = ~clk;

  icache_tagv_nway #(
    .WAY(WAY),
    .INDEX_W(INDEX_W),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rd_en(rd_en),
    .rd_index(rd_index),
    .rd_tag(rd_tag),
    .wr_en(wr_en),
    .wr_way(wr_way),
    .wr_index(wr_index),
    .wr_tag(wr_tag),
    .wr_valid(wr_valid),
    .inv_req(inv_req),
    .inv_all(inv_all),
    .inv_index(inv_index),
    .ready(ready),
    .rd_out_valid(rd_out_valid),
    .hit(hit),
    .hit_any(hit_any),
    .hit_way(hit_way),
    .victim(victim)
  );

  always @(posedge clk) begin
    if (rstn && ready) begin
      assert (!(inv_req && wr_en))
        else $error("inv_req and wr_en in same cycle");
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rd_en     = 1'b0;
    rd_index  = '0;
    rd_tag    = '0;
    wr_en     = 1'b0;
    wr_way    = '0;
    wr_index  = '0;
    wr_tag    = '0;
    wr_valid  = 1'b0;
    inv_req   = 1'b0;
    inv_all   = 1'b0;
    inv_index = '0;
  endtask

  task automatic clearModel();
    for (int w = 0; w < WAY; w++)
      for (int s = 0; s < SETS; s++) begin
        mV[w][s] = 1'b0;
        mT[w][s] = '0;
      end
  endtask

  // Called at a negedge with inputs already driven
  task automatic cyc();
    bit             rdy;
    bit             expRv;
    bit [WAY-1:0]   expHit;
    bit [WAY-1:0]   expVic;
    int             expWay;
    int             s;
    rdy = (busy == 0);
    chk("ready", 32'(ready), 32'(rdy));
    @(posedge clk);
    if (pendInv) begin
      for (int w = 0; w < WAY; w++)
        for (int k = 0; k < SETS; k++)
          if (pendAll || k == pendIdx) mV[w][k] = 1'b0;
      pendInv = 1'b0;
    end
    if (!rdy) begin
      busy--;
    end else if (inv_req) begin
      pendInv = 1'b1;
      pendAll = inv_all;
      pendIdx = int'(inv_index);
      busy    = inv_all ? SETS : 1;
    end else if (wr_en) begin
      for (int w = 0; w < WAY; w++)
        if (wr_way[w]) begin
          mV[w][wr_index] = wr_valid;
          mT[w][wr_index] = wr_tag;
        end
    end
    expRv  = rd_en;
    expHit = '0;
    expVic = '0;
    expWay = 0;
    if (rd_en && rdy) begin
      s = int'(rd_index);
      for (int w = WAY - 1; w >= 0; w--)
        if (mV[w][s] && mT[w][s] == rd_tag) begin
          expHit[w] = 1'b1;
          expWay    = w;
        end
      for (int w = WAY - 1; w >= 0; w--)
        if (!mV[w][s]) expVic = WAY'(1) << w;
      if (expVic == 0)
        expVic = WAY'(1) << (lfsrM % 4);
    end
    if (rd_en) begin
      if (lfsrM % 2 == 1) lfsrM = (lfsrM / 2) ^ 8'hB8;
      else                lfsrM = lfsrM / 2;
    end
    @(negedge clk);
    chk("rvalid", 32'(rd_out_valid), 32'(expRv));
    if (expRv) begin
      chk("hit", 32'(hit), 32'(expHit));
      chk("hitAny", 32'(hit_any), 32'(expHit != 0));
      chk("hitWay", 32'(hit_way), 32'(expWay));
      chk("victim", 32'(victim), 32'(expVic));
      chk("oneHit", 32'($countones(hit) <= 1), 32'd1);
    end
  endtask

  task automatic doReset(input int hold);
    @(negedge clk);
    idle();
    rstn = 1'b0;
    repeat (hold) @(negedge clk);
    chk("rstReady", 32'(ready), 32'd0);
    chk("rstRv", 32'(rd_out_valid), 32'd0);
    chk("rstHit", 32'(hit), 32'd0);
    chk("rstVic", 32'(victim), 32'd0);
    rstn    = 1'b1;
    busy    = SETS;
    lfsrM   = 8'h01;
    pendInv = 1'b0;
    clearModel();
  endtask

  task automatic look(input int idx, input int tag);
    idle();
    rd_en    = 1'b1;
    rd_index = INDEX_W'(idx);
    rd_tag   = TAG_W'(tag);
  endtask

  task automatic wr(input int way, input int idx,
                    input int tag, input bit v);
    wr_en    = 1'b1;
    wr_way   = WAY'(1) << way;
    wr_index = INDEX_W'(idx);
    wr_tag   = TAG_W'(tag);
    wr_valid = v;
  endtask

  task automatic allMiss();
    for (int s = 0; s < SETS; s++) begin
      look(s, int'($urandom));
      cyc();
    end
    idle();
    cyc();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    doReset(3);

    // INIT: lookups while busy return empty results
    for (int i = 0; i < SETS; i++) begin
      look(int'($urandom_range(0, SETS - 1)), i);
      rd_en = (i % 3 == 0);
      cyc();
    end
    allMiss();

    // Write then look up next cycle
    idle();
    wr(2, 5, 'hABCDE, 1'b1);
    cyc();
    look(5, 'hABCDE);
    cyc();

    // Same-cycle write and lookup (forwarding)
    look(9, 'h12345);
    wr(1, 9, 'h12345, 1'b1);
    cyc();

    // Full set: victim comes from the LFSR
    idle();
    for (int w = 0; w < WAY; w++) begin
      wr(w, 3, 'h300 + w, 1'b1);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      look(3, 'h300 + i);
      cyc();
    end

    // Single-set invalidate
    idle();
    wr(0, 7, 'h777, 1'b1);
    cyc();
    idle();
    inv_req   = 1'b1;
    inv_index = 6'd3;
    cyc();
    idle();
    cyc();
    look(3, 'h301);
    cyc();
    look(7, 'h777);
    cyc();

    // Random traffic on a few sets with way-tagged tags
    for (int i = 0; i < 500; i++) begin
      int w;
      idle();
      if ($urandom_range(0, 1) == 1)
        look(int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)));
      if ($urandom_range(0, 99) < 3) begin
        inv_req   = 1'b1;
        inv_index = INDEX_W'($urandom_range(0, 7));
      end else if ($urandom_range(0, 2) == 0) begin
        w = int'($urandom_range(0, WAY - 1));
        wr(w, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)) * 4 + w,
           ($urandom_range(0, 4) != 0));
      end
      cyc();
    end

    // Whole-array sweep cut short by reset
    idle();
    inv_req = 1'b1;
    inv_all = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 19; i++) cyc();
    doReset(1);
    for (int i = 0; i < SETS; i++) cyc();
    allMiss();

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
